// File: rtl/min_scan_ctrl.sv
// Min-search engine: scans LEN signed words from base_adr and writes the minimum and its
// index to RES_ADR/RES_ADR+4. While it scans it owns data_mem, and CPU accesses are stalled.
module min_scan_ctrl #(
  parameter int          LEN_W   = 16,
  parameter logic [31:0] RES_ADR = 32'd2000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      cpu_adr,
  input  logic [31:0]      cpu_din,
  input  logic             cpu_mrd,
  input  logic             cpu_mwr,
  input  logic [31:0]      mem_dout,
  output logic [31:0]      mem_adr,
  output logic [31:0]      mem_din,
  output logic             mem_mrd,
  output logic             mem_mwr,
  output logic             cpu_stall,
  output logic             busy,
  output logic             done,
  output logic [31:0]      min_val,
  output logic [31:0]      min_idx
);

  typedef enum logic [2:0] {IDLE, SCAN, WR_VAL, WR_IDX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      base_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] i_reg;
  logic [31:0]      cur_min_reg;
  logic [LEN_W-1:0] cur_idx_reg;
  logic [31:0]      min_val_reg;
  logic [31:0]      min_idx_reg;
  logic [31:0]      scan_adr;

  assign scan_adr = base_reg + (32'(i_reg) << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg    <= '0;
      len_reg     <= '0;
      i_reg       <= '0;
      cur_min_reg <= '0;
      cur_idx_reg <= '0;
      min_val_reg <= '0;
      min_idx_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg <= base_adr;
            len_reg  <= len;
            i_reg    <= '0;
          end
        end
        SCAN: begin
          // Strict less-than keeps the first occurrence on ties.
          if (i_reg == '0 || $signed(mem_dout) < $signed(cur_min_reg)) begin
            cur_min_reg <= mem_dout;
            cur_idx_reg <= i_reg;
          end
          i_reg <= i_reg + 1'b1;
        end
        WR_IDX: begin
          min_val_reg <= cur_min_reg;
          min_idx_reg <= 32'(cur_idx_reg);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_adr    = cpu_adr;
    mem_din    = cpu_din;
    mem_mrd    = cpu_mrd;
    mem_mwr    = cpu_mwr;
    cpu_stall  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (len == '0) ? DONE : SCAN;
      end
      SCAN: begin
        mem_adr   = scan_adr;
        mem_din   = '0;
        mem_mrd   = 1'b1;
        mem_mwr   = 1'b0;
        cpu_stall = cpu_mrd | cpu_mwr;
        busy      = 1'b1;
        if (i_reg == len_reg - 1'b1) state_next = WR_VAL;
      end
      WR_VAL: begin
        mem_adr    = RES_ADR;
        mem_din    = cur_min_reg;
        mem_mrd    = 1'b0;
        mem_mwr    = 1'b1;
        cpu_stall  = cpu_mrd | cpu_mwr;
        busy       = 1'b1;
        state_next = WR_IDX;
      end
      WR_IDX: begin
        mem_adr    = RES_ADR + 32'd4;
        mem_din    = 32'(cur_idx_reg);
        mem_mrd    = 1'b0;
        mem_mwr    = 1'b1;
        cpu_stall  = cpu_mrd | cpu_mwr;
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign min_val = min_val_reg;
  assign min_idx = min_idx_reg;

endmodule

// File: tb/tb_min_scan_ctrl.sv
// Directed bench for min_scan_ctrl with a behavioural data_mem; expected scan results are
// queued when a scan is launched and compared when the done pulse arrives.
module tb_min_scan_ctrl;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base_adr = '0;
  logic [LEN_W-1:0] len = '0;
  logic [31:0]      cpu_adr = '0;
  logic [31:0]      cpu_din = '0;
  logic             cpu_mrd = 1'b0;
  logic             cpu_mwr = 1'b0;
  logic [31:0]      mem_dout;
  logic [31:0]      mem_adr, mem_din, min_val, min_idx;
  logic             mem_mrd, mem_mwr, cpu_stall, busy, done;

  min_scan_ctrl #(.LEN_W(LEN_W), .RES_ADR(32'd2000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .len(len),
    .cpu_adr(cpu_adr), .cpu_din(cpu_din), .cpu_mrd(cpu_mrd), .cpu_mwr(cpu_mwr),
    .mem_dout(mem_dout), .mem_adr(mem_adr), .mem_din(mem_din), .mem_mrd(mem_mrd),
    .mem_mwr(mem_mwr), .cpu_stall(cpu_stall), .busy(busy), .done(done),
    .min_val(min_val), .min_idx(min_idx)
  );

  always #5 clk = ~clk;

  // 4 KB data memory, address bits above 11 ignored (so wrapped addresses alias low words).
  logic [31:0] tb_mem [0:1023];
  assign mem_dout = tb_mem[mem_adr[11:2]];
  always @(posedge clk) if (mem_mwr) tb_mem[mem_adr[11:2]] <= mem_din;

  typedef struct {
    logic [31:0] v;
    logic [31:0] i;
    logic [31:0] mv;
    logic [31:0] mi;
    int          dc;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] last_v = '0, last_i = '0, mem_v = '0, mem_i = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    cpu_adr = a;
    cpu_din = d;
    cpu_mwr = 1'b1;
    tick();
    cpu_mwr = 1'b0;
  endtask

  task automatic load(input logic [31:0] base, input int data[$]);
    for (int k = 0; k < data.size(); k++) wr_word(base + 32'(4 * k), 32'(data[k]));
  endtask

  task automatic run_scan(input logic [31:0] base, input int data[$],
                          input bit hold_rd, input bit pulse);
    exp_t        e;
    int          n;
    int          cyc, dcyc, busy_n, stall_n;
    bit          acc;
    logic [31:0] m;
    int          mi;
    n = data.size();
    if (n > 0) begin
      m  = 32'(data[0]);
      mi = 0;
      for (int k = 1; k < n; k++)
        if (data[k] < $signed(m)) begin
          m  = 32'(data[k]);
          mi = k;
        end
      last_v = m;
      last_i = 32'(mi);
      mem_v  = m;
      mem_i  = 32'(mi);
    end
    e.v  = last_v;
    e.i  = last_i;
    e.mv = mem_v;
    e.mi = mem_i;
    e.dc = (n == 0) ? 1 : n + 3;
    sb.push_back(e);

    base_adr = base;
    len      = LEN_W'(n);
    start    = 1'b1;
    cpu_adr  = 32'h0000_0ABC;
    cpu_mrd  = hold_rd;
    tick();
    start    = 1'b0;
    base_adr = 32'h0;
    len      = LEN_W'(3);
    cyc = 1; dcyc = -1; busy_n = 0; stall_n = 0; acc = 1'b0;
    while (cyc < n + 10) begin
      if (busy) busy_n++;
      if (cpu_stall) stall_n++;
      if (mem_mrd || mem_mwr) acc = 1'b1;
      if (done) begin
        dcyc = cyc;
        check("stall_in_done", {31'b0, cpu_stall}, 32'd0);
        check("pass_adr_in_done", mem_adr, cpu_adr);
        start = pulse;
        break;
      end
      start = pulse && (cyc == 3 || cyc == n + 1);
      tick();
      cyc++;
    end
    check("done_cycle", 32'(dcyc), 32'(e.dc));
    check("busy_cycles", 32'(busy_n), (n == 0) ? 32'd0 : 32'(n + 2));
    check("stall_cycles", 32'(stall_n), (hold_rd && n > 0) ? 32'(n + 2) : 32'd0);
    if (n == 0) check("len0_no_access", {31'b0, acc}, 32'd0);
    tick();
    start   = 1'b0;
    cpu_mrd = 1'b0;
    check("busy_after_done", {31'b0, busy}, 32'd0);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    e = sb.pop_front();
    check("min_val", min_val, e.v);
    check("min_idx", min_idx, e.i);
    check("mem_res_val", tb_mem[500], e.mv);
    check("mem_res_idx", tb_mem[501], e.mi);
    $display("scan base=%h len=%0d min_val=%h min_idx=%0d done_cycle=%0d",
             base, n, min_val, min_idx, dcyc);
  endtask

  int d20[$]  = '{12, 13, 21, 31, 44, 53, 19, 2, -11, 49, 52, 13, 27, 36, 45, 51, 71, 62, 93, -84};
  int dtie[$] = '{5, -3, 7, -3};
  int d1[$]   = '{32'h8000_0000};
  int d0[$];
  int dwr[$]  = '{9, 100, -7, 3};

  initial begin
    int dn;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_min_val", min_val, 32'd0);
    check("rst_min_idx", min_idx, 32'd0);
    check("rst_mem_rw", {30'b0, mem_mrd, mem_mwr}, 32'd0);
    check("rst_stall", {31'b0, cpu_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    wr_word(32'd2000, 32'hDEAD_BEEF);
    wr_word(32'd2004, 32'hCAFE_F00D);
    mem_v = 32'hDEAD_BEEF;
    mem_i = 32'hCAFE_F00D;

    load(32'd1000, d20);
    run_scan(32'd1000, d20, 1'b0, 1'b0);
    check("spec_min_val", min_val, 32'hFFFF_FFAC);
    check("spec_min_idx", min_idx, 32'd19);

    load(32'd3000, dtie);
    run_scan(32'd3000, dtie, 1'b1, 1'b1);

    load(32'd3100, d1);
    run_scan(32'd3100, d1, 1'b0, 1'b0);

    run_scan(32'd3200, d0, 1'b0, 1'b0);

    // Abort a scan with reset in cycle 5.
    base_adr = 32'd1000;
    len      = LEN_W'(20);
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("busy_before_rst", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_mem_rw", {30'b0, mem_mrd, mem_mwr}, 32'd0);
    repeat (3) tick();
    check("rst_mid_min_val", min_val, 32'd0);
    check("rst_mid_min_idx", min_idx, 32'd0);
    rst_n = 1'b1;
    last_v = '0;
    last_i = '0;
    dn = 0;
    repeat (30) begin
      if (done || busy) dn++;
      tick();
    end
    check("rst_no_resume", 32'(dn), 32'd0);
    check("rst_mem_val", tb_mem[500], mem_v);
    check("rst_mem_idx", tb_mem[501], mem_i);

    load(32'hFFFF_FFF8, dwr);
    run_scan(32'hFFFF_FFF8, dwr, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
